// File: rtl/mux4_rr_arbiter_pkg.sv
// rtl/mux4_rr_arbiter_pkg.sv - shared types and helpers for the 4-way round-robin arbiter
package mux4_pkg;

   localparam int NUM_REQ = 4;

   typedef enum logic [0:0] {IDLE = 1'b0, GRANT = 1'b1} state_t;

   function automatic logic [3:0] onehot4(input logic [1:0] idx);
      return 4'b0001 << idx;
   endfunction

   // Returns {found, idx}; scans downward in distance so the nearest set bit from ptr wins.
   function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
      logic [2:0] res;
      logic [1:0] j;
      res = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         j = ptr + 2'(k);
         if (req[j]) res = {1'b1, j};
      end
      return res;
   endfunction

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// rtl/mux4_rr_arbiter_if.sv - requester/consumer bundle for the 4-way arbiter
interface mux4_rr_arbiter_if;
   logic [3:0] req;
   logic       a;
   logic       b;
   logic       c;
   logic       d;
   logic       out_ready;
   logic [3:0] select;
   logic       out;
   logic       out_valid;
   logic [1:0] grant_idx;

   modport master (
      output req, a, b, c, d, out_ready,
      input  select, out, out_valid, grant_idx
   );

   modport slave (
      input  req, a, b, c, d, out_ready,
      output select, out, out_valid, grant_idx
   );
endinterface

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
// rtl/mux4_rr_arbiter_rr_pick4.sv - combinational circular priority scan starting at ptr
module rr_pick4
   import mux4_pkg::*;
(
   input  logic [3:0] req_i,
   input  logic [1:0] ptr_i,
   output logic       found_o,
   output logic [1:0] idx_o
);

   assign {found_o, idx_o} = rr_pick(req_i, ptr_i);

endmodule

// File: rtl/mux4_rr_arbiter.sv
// rtl/mux4_rr_arbiter.sv - round-robin arbiter driving a one-hot 4:1 bit mux with valid/ready output
module mux4_rr_arbiter
   import mux4_pkg::*;
#(
   parameter int MAX_HOLD = 4,
   parameter int CNT_W    = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   mux4_rr_arbiter_if.slave     bus
);

   localparam logic [0:0] S_IDLE  = 1'(IDLE);
   localparam logic [0:0] S_GRANT = 1'(GRANT);

   logic [0:0]       state_q, state_d;
   logic [3:0]       sel_q, sel_d;
   logic [1:0]       idx_q, idx_d;
   logic [1:0]       ptr_q, ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             valid_q, valid_d;

   logic       xfer;
   logic       at_limit;
   logic       others;
   logic       release_g;
   logic [3:0] pick_req;
   logic [1:0] pick_ptr;
   logic       pick_found;
   logic [1:0] pick_idx;

   assign xfer      = valid_q & bus.out_ready;
   assign at_limit  = (cnt_q == CNT_W'(MAX_HOLD - 1));
   assign others    = |(bus.req & ~onehot4(idx_q));
   assign release_g = (state_q == S_GRANT) &&
                      (!bus.req[idx_q] || (xfer && at_limit && others));

   // On release the current holder is masked and the scan starts just past it.
   assign pick_req = (state_q == S_GRANT) ? (bus.req & ~onehot4(idx_q)) : bus.req;
   assign pick_ptr = (state_q == S_GRANT) ? (idx_q + 2'd1) : ptr_q;

   rr_pick4 u_pick (
      .req_i   (pick_req),
      .ptr_i   (pick_ptr),
      .found_o (pick_found),
      .idx_o   (pick_idx)
   );

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      idx_d   = idx_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      valid_d = valid_q;
      if (state_q == S_IDLE || release_g) begin
         if (release_g) ptr_d = idx_q + 2'd1;
         cnt_d = '0;
         if (pick_found) begin
            state_d = S_GRANT;
            sel_d   = onehot4(pick_idx);
            idx_d   = pick_idx;
            valid_d = 1'b1;
         end else begin
            state_d = S_IDLE;
            sel_d   = 4'b0000;
            idx_d   = 2'd0;
            valid_d = 1'b0;
         end
      end else if (xfer) begin
         cnt_d = at_limit ? '0 : cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         sel_q   <= 4'b0000;
         idx_q   <= 2'd0;
         ptr_q   <= 2'd0;
         cnt_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         idx_q   <= idx_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
      end
   end

   assign bus.select    = sel_q;
   assign bus.grant_idx = idx_q;
   assign bus.out_valid = valid_q;
   assign bus.out       = |(sel_q & {bus.d, bus.c, bus.b, bus.a});

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb/tb_mux4_rr_arbiter.sv - randomized and directed bench for mux4_rr_arbiter against a behavioural model
module tb_mux4_rr_arbiter;

   localparam int MAX_HOLD = 4;

   logic clk;
   logic rst;
   mux4_rr_arbiter_if bus ();

   mux4_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Model: holder is -1 when nothing is granted; beats counts accepted beats in this window.
   int m_holder = -1;
   int m_ptr    = 0;
   int m_beats  = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int scan_from(input logic [3:0] rq, input int start);
      for (int k = 0; k < 4; k++) begin
         int j;
         j = (start + k) % 4;
         if (rq[j]) return j;
      end
      return -1;
   endfunction

   task automatic model_step(input logic r, input logic [3:0] rq, input logic rdy);
      bit   accepted;
      bit   rivals;
      logic [3:0] masked;
      int   w;
      accepted = (m_holder >= 0) && rdy;
      if (r) begin
         m_holder = -1;
         m_ptr    = 0;
         m_beats  = 0;
      end else if (m_holder < 0) begin
         w = scan_from(rq, m_ptr);
         if (w >= 0) begin
            m_holder = w;
            m_beats  = 0;
         end
      end else begin
         masked = rq;
         masked[m_holder] = 1'b0;
         rivals = (masked != 4'b0000);
         if (!rq[m_holder] || (accepted && rivals && (m_beats + 1 == MAX_HOLD))) begin
            m_ptr    = (m_holder + 1) % 4;
            m_holder = scan_from(masked, m_ptr);
            m_beats  = 0;
         end else if (accepted) begin
            m_beats = (m_beats + 1) % MAX_HOLD;
         end
      end
   endtask

   task automatic cyc(input logic r, input logic [3:0] rq, input logic [3:0] dat, input logic rdy);
      logic [3:0] exp_sel;
      @(negedge clk);
      rst           = r;
      bus.req       = rq;
      {bus.d, bus.c, bus.b, bus.a} = dat;
      bus.out_ready = rdy;
      #1;
      exp_sel = (m_holder < 0) ? 4'b0000 : (4'b0001 << m_holder);
      chk("select", 32'(bus.select), 32'(exp_sel));
      chk("grant_idx", 32'(bus.grant_idx), (m_holder < 0) ? 32'd0 : 32'(m_holder));
      chk("out_valid", 32'(bus.out_valid), (m_holder < 0) ? 32'd0 : 32'd1);
      chk("out", 32'(bus.out), (m_holder < 0) ? 32'd0 : 32'(dat[m_holder]));
      model_step(r, rq, rdy);
   endtask

   initial begin
      logic [3:0] rq;
      rst           = 1'b1;
      bus.req       = 4'b0000;
      {bus.d, bus.c, bus.b, bus.a} = 4'b0000;
      bus.out_ready = 1'b0;

      // Reset and idle
      cyc(1'b1, 4'b0000, 4'b1111, 1'b1);
      cyc(1'b1, 4'b0000, 4'b1111, 1'b1);
      cyc(1'b0, 4'b0000, 4'b1111, 1'b1);
      cyc(1'b0, 4'b0000, 4'b1111, 1'b1);
      chk("idle_select", 32'(bus.select), 32'd0);

      // Single requester on c, then drop; ptr moves to 3
      cyc(1'b0, 4'b0100, 4'b0100, 1'b1);
      cyc(1'b0, 4'b0100, 4'b0100, 1'b1);
      chk("single_c_select", 32'(bus.select), 32'h4);
      chk("single_c_out", 32'(bus.out), 32'd1);
      cyc(1'b0, 4'b0000, 4'b0100, 1'b1);
      cyc(1'b0, 4'b1001, 4'($urandom), 1'b1);
      cyc(1'b0, 4'b1001, 4'($urandom), 1'b1);
      chk("ptr3_picks_d", 32'(bus.grant_idx), 32'd3);

      // Round robin under full load
      cyc(1'b1, 4'b0000, 4'b0000, 1'b1);
      for (int i = 0; i < 22; i++) cyc(1'b0, 4'b1111, 4'($urandom), 1'b1);

      // Backpressure on b
      cyc(1'b1, 4'b0000, 4'b0000, 1'b1);
      cyc(1'b0, 4'b0010, 4'($urandom), 1'b0);
      for (int i = 0; i < 5; i++) cyc(1'b0, 4'b1111, 4'($urandom), 1'b0);
      chk("bp_hold_b", 32'(bus.select), 32'h2);
      for (int i = 0; i < 6; i++) cyc(1'b0, 4'b1111, 4'($urandom), 1'b1);

      // Sole requester beyond MAX_HOLD
      cyc(1'b1, 4'b0000, 4'b0000, 1'b1);
      for (int i = 0; i < 12; i++) cyc(1'b0, 4'b0001, 4'($urandom), 1'b1);
      chk("sole_a_kept", 32'(bus.select), 32'h1);

      // Mid-grant reset, then b wins from ptr=0
      cyc(1'b1, 4'b0000, 4'b0000, 1'b1);
      cyc(1'b0, 4'b1000, 4'($urandom), 1'b1);
      cyc(1'b0, 4'b1000, 4'($urandom), 1'b1);
      cyc(1'b0, 4'b1000, 4'($urandom), 1'b1);
      cyc(1'b1, 4'b1000, 4'($urandom), 1'b1);
      cyc(1'b0, 4'b1010, 4'($urandom), 1'b1);
      chk("rst_clears_valid", 32'(bus.out_valid), 32'd0);
      cyc(1'b0, 4'b1010, 4'($urandom), 1'b1);
      chk("rst_then_b", 32'(bus.grant_idx), 32'd1);

      // Random traffic
      rq = 4'($urandom);
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 3) == 0) rq = 4'($urandom);
         cyc(($urandom_range(0, 59) == 0), rq, 4'($urandom), ($urandom_range(0, 3) != 0));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
